// File: rtl/frame_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_tx_pkg
// Purpose  : Shared types, default constants and the frame-config check for
//            the frame_pixel_tx transmitter.
// Contents : tx_state_t  - transmitter FSM state encoding
//            c_DWIDTH    - default bits per pixel
//            c_LANES     - default pixels per beat
//            cfg_ok()    - legality check for a start request
// Revision : 1.0 - initial release
// ============================================================================
package frame_tx_pkg;

  localparam int c_DWIDTH = 10;
  localparam int c_LANES  = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_NEWF = 3'd1,
    ST_LEAD = 3'd2,
    ST_GAP  = 3'd3,
    ST_ROW  = 3'd4,
    ST_DONE = 3'd5
  } tx_state_t;

  // A frame is legal when it has at least one row and its row length is a
  // non-zero whole number of beats (lanes is a power of two).
  function automatic logic cfg_ok(input logic [31:0] rows,
                                  input logic [31:0] cols,
                                  input int          lanes);
    logic [31:0] w_mask;
    w_mask = 32'(lanes - 1);
    return (rows != 32'd0) && (cols != 32'd0) && ((cols & w_mask) == 32'd0);
  endfunction

endpackage : frame_tx_pkg
`default_nettype wire

// File: rtl/frame_pixel_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_pixel_tx_if
// Purpose  : Pixel path of the frame transmitter: upstream ready/valid stream
//            in, filter-side frame/pixel signals out.
// Signals  : s_data/s_valid/s_ready - upstream beat handshake
//            new_frame              - one-cycle frame pulse to the filter
//            data_in/data_vld       - lane-reversed pixels to the filter
// Modports : master - the transmitter
//            slave  - the environment (source + filter)
// Revision : 1.0 - initial release
// ============================================================================
interface frame_pixel_tx_if
  import frame_tx_pkg::*;
#(
  parameter int DWIDTH = c_DWIDTH,
  parameter int LANES  = c_LANES
) ();

  logic [LANES*DWIDTH-1:0] s_data;
  logic                    s_valid;
  logic                    s_ready;
  logic                    new_frame;
  logic [LANES*DWIDTH-1:0] data_in;
  logic                    data_vld;

  modport master (
    input  s_data,
    input  s_valid,
    output s_ready,
    output new_frame,
    output data_in,
    output data_vld
  );

  modport slave (
    output s_data,
    output s_valid,
    input  s_ready,
    input  new_frame,
    input  data_in,
    input  data_vld
  );

endinterface : frame_pixel_tx_if
`default_nettype wire

// File: rtl/pixel_lane_swap.sv
`default_nettype none
// ============================================================================
// Module   : pixel_lane_swap
// Purpose  : Purely combinational lane reversal of a multi-pixel beat, so the
//            earliest pixel (lane 0) ends up in the most significant lane.
// Ports    : i_data - LANES*DWIDTH input beat, lane 0 in the LSBs
//            o_data - LANES*DWIDTH output beat, lane order reversed
// Revision : 1.0 - initial release
// ============================================================================
module pixel_lane_swap #(
  parameter int DWIDTH = 10,
  parameter int LANES  = 8
) (
  input  wire logic [LANES*DWIDTH-1:0] i_data,
  output logic      [LANES*DWIDTH-1:0] o_data
);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign o_data[(LANES-1-k)*DWIDTH +: DWIDTH] = i_data[k*DWIDTH +: DWIDTH];
  end

endmodule : pixel_lane_swap
`default_nettype wire

// File: rtl/frame_pixel_tx.sv
`default_nettype none
// ============================================================================
// Module   : frame_pixel_tx
// Purpose  : Frame transmitter. On an accepted start it pulses new_frame,
//            waits LEAD idle cycles, then for each row waits ROW_GAP idle
//            cycles and accepts colSize/LANES upstream beats, forwarding each
//            one lane-reversed on data_in/data_vld one cycle later.
// Ports    : sys_clk, sys_rst_n     - clock, async active-low reset
//            start, abort           - frame request / synchronous cancel
//            rowSize, colSize       - frame geometry, latched at start
//            px (master)            - upstream stream + filter pixel outputs
//            busy, done, cfg_err    - status pulses / level
//            underflow              - sticky mid-row bubble flag
// Revision : 1.0 - initial release
// ============================================================================
module frame_pixel_tx
  import frame_tx_pkg::*;
#(
  parameter int DWIDTH  = c_DWIDTH,
  parameter int LANES   = c_LANES,
  parameter int LEAD    = 4,
  parameter int ROW_GAP = 1
) (
  input  wire logic        sys_clk,
  input  wire logic        sys_rst_n,
  input  wire logic        start,
  input  wire logic        abort,
  input  wire logic [31:0] rowSize,
  input  wire logic [31:0] colSize,
  frame_pixel_tx_if.master px,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             underflow
);

  localparam int          c_SHIFT     = $clog2(LANES);
  localparam int          c_W         = LANES * DWIDTH;
  // Last count value of each idle phase; the LEAD phase is skipped when 0.
  localparam logic [31:0] c_LEAD_LAST = (LEAD > 0)    ? 32'(LEAD - 1)    : 32'd0;
  localparam logic [31:0] c_GAP_LAST  = (ROW_GAP > 0) ? 32'(ROW_GAP - 1) : 32'd0;

  tx_state_t        r_state;
  tx_state_t        w_next;
  logic [31:0]      r_rows;
  logic [31:0]      r_bpr;
  logic [31:0]      r_beat;
  logic [31:0]      r_row;
  logic [31:0]      r_wait;
  logic [c_W-1:0]   r_data;
  logic             r_vld;
  logic             r_cfg_err;
  logic             r_underflow;

  logic             w_hs;
  logic             w_start_ok;
  logic             w_last_beat;
  logic             w_last_row;
  logic [c_W-1:0]   w_swapped;

  // s_ready depends on the registered state only.
  assign w_hs        = px.s_valid & (r_state == ST_ROW);
  assign w_start_ok  = start & cfg_ok(rowSize, colSize, LANES);
  assign w_last_beat = (r_beat == (r_bpr - 32'd1));
  assign w_last_row  = (r_row == (r_rows - 32'd1));

  pixel_lane_swap #(
    .DWIDTH (DWIDTH),
    .LANES  (LANES)
  ) u_swap (
    .i_data (px.s_data),
    .o_data (w_swapped)
  );

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start_ok) w_next = ST_NEWF;
      ST_NEWF: w_next = (LEAD == 0) ? ST_GAP : ST_LEAD;
      ST_LEAD: if (r_wait == c_LEAD_LAST) w_next = ST_GAP;
      ST_GAP:  if (r_wait == c_GAP_LAST) w_next = ST_ROW;
      ST_ROW:  if (w_hs && w_last_beat) w_next = w_last_row ? ST_DONE : ST_GAP;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    // Cancel beats everything except a start taken from IDLE.
    if (abort && (r_state != ST_IDLE)) w_next = ST_IDLE;
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    px.s_ready   = (r_state == ST_ROW);
    px.new_frame = (r_state == ST_NEWF);
    done         = (r_state == ST_DONE);
    busy         = (r_state != ST_IDLE);
  end

  assign px.data_in  = r_data;
  assign px.data_vld = r_vld;
  assign cfg_err     = r_cfg_err;
  assign underflow   = r_underflow;

  // --------------------------------------------------------- counters / config
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rows <= 32'd0;
      r_bpr  <= 32'd0;
      r_beat <= 32'd0;
      r_row  <= 32'd0;
      r_wait <= 32'd0;
    end else begin
      if ((r_state == ST_IDLE) && w_start_ok) begin
        r_rows <= rowSize;
        r_bpr  <= colSize >> c_SHIFT;
      end

      // Idle-phase counter restarts on every state change.
      if (r_state != w_next) r_wait <= 32'd0;
      else                   r_wait <= r_wait + 32'd1;

      if (r_state == ST_GAP) r_beat <= 32'd0;
      else if (w_hs)         r_beat <= r_beat + 32'd1;

      if (r_state == ST_IDLE)                       r_row <= 32'd0;
      else if (w_hs && w_last_beat && !w_last_row)  r_row <= r_row + 32'd1;
    end
  end

  // ----------------------------------------------------------- data / status
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_data      <= '0;
      r_vld       <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_hs) r_data <= w_swapped;
      r_vld     <= w_hs;
      r_cfg_err <= (r_state == ST_IDLE) && start && !w_start_ok;

      // A missing beat after the row has started is a bubble; waiting for
      // the first beat of a row is not.
      if ((r_state == ST_IDLE) && w_start_ok)
        r_underflow <= 1'b0;
      else if ((r_state == ST_ROW) && !px.s_valid && (r_beat != 32'd0))
        r_underflow <= 1'b1;
    end
  end

endmodule : frame_pixel_tx
`default_nettype wire

// File: tb/tb_frame_pixel_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_pixel_tx
// Purpose  : Self-checking bench for frame_pixel_tx. An upstream source feeds
//            numbered beats; every accepted beat pushes its lane-reversed
//            image to a scoreboard that is popped on each data_vld.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_pixel_tx;

  localparam int DW = 10;
  localparam int L  = 8;
  localparam int W  = DW * L;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start     = 1'b0;
  logic        abort     = 1'b0;
  logic [31:0] rowSize   = 32'd0;
  logic [31:0] colSize   = 32'd0;
  logic        busy, done, cfg_err, underflow;

  frame_pixel_tx_if #(.DWIDTH(DW), .LANES(L)) u ();

  frame_pixel_tx #(
    .DWIDTH (DW),
    .LANES  (L),
    .LEAD   (4),
    .ROW_GAP(1)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .abort     (abort),
    .rowSize   (rowSize),
    .colSize   (colSize),
    .px        (u),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .underflow (underflow)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] sb[$];
  int hs_total = 0;

  // source state
  int hs_base, last_b, bubble_after, bubble_len, bubble_rem;
  bit src_on = 1'b0;

  // per-frame record
  int rel, nf_cnt, nf_cyc, rdy_first, done_cnt, done_cyc, cfgerr_cnt;
  int busy_abort, busy_at1;
  int vld_q[$];
  logic [W-1:0] first_data;
  bit got_first;

  function automatic logic [W-1:0] pattern(input int b);
    logic [W-1:0] p;
    p = '0;
    for (int k = 0; k < L; k++) p[k*DW +: DW] = DW'(b * L + k + 1);
    return p;
  endfunction

  function automatic logic [W-1:0] swap(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < L; k++) r[(L-1-k)*DW +: DW] = d[k*DW +: DW];
    return r;
  endfunction

  // Scoreboard: pop on output first (older beat), then push this cycle's.
  always @(negedge sys_clk) begin
    logic [W-1:0] exp_d;
    if (u.data_vld === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_underrun: data_vld with data %h but no expected beat", u.data_in);
      end else begin
        exp_d = sb.pop_front();
        if (u.data_in !== exp_d) begin
          fails++;
          $display("FAIL sb_data: got %h expected %h", u.data_in, exp_d);
        end
      end
    end
    if ((u.s_valid === 1'b1) && (u.s_ready === 1'b1)) begin
      sb.push_back(swap(u.s_data));
      hs_total++;
    end
  end

  task automatic step();
    int b;
    @(posedge sys_clk);
    #1;
    b = hs_total - hs_base;
    if (b != last_b) begin
      last_b   = b;
      u.s_data = pattern(b);
      if (b == bubble_after) bubble_rem = bubble_len;
    end
    u.s_valid = src_on && (bubble_rem == 0);
    if (bubble_rem > 0) bubble_rem--;
  endtask

  task automatic run_frame(input int rows, input int cols, input int abort_at,
                           input int restart_at, input int b_after, input int b_len);
    bit fin;
    nf_cnt = 0; nf_cyc = -1; rdy_first = -1; done_cnt = 0; done_cyc = -1;
    cfgerr_cnt = 0; busy_abort = -1; busy_at1 = -1; got_first = 0; first_data = '0;
    vld_q.delete();
    hs_base = hs_total; last_b = 0;
    bubble_after = b_after; bubble_len = b_len; bubble_rem = 0;
    u.s_data = pattern(0); src_on = 1'b1; u.s_valid = 1'b1;
    rowSize = rows; colSize = cols; start = 1'b1; abort = 1'b0;
    rel = 0; fin = 0;
    while (!fin && rel < 200) begin
      step();
      rel++;
      if (u.new_frame) begin nf_cnt++; nf_cyc = rel; end
      if (u.s_ready && rdy_first < 0) rdy_first = rel;
      if (u.data_vld) begin
        vld_q.push_back(rel);
        if (!got_first) begin first_data = u.data_in; got_first = 1; end
      end
      if (done) begin done_cnt++; done_cyc = rel; end
      if (cfg_err) cfgerr_cnt++;
      if (rel == 1) busy_at1 = int'(busy);
      if (rel == abort_at + 1) busy_abort = int'(busy);
      start = (rel == restart_at);
      if (rel == restart_at) begin rowSize = 5; colSize = 12; end
      else begin rowSize = rows; colSize = cols; end
      abort = (rel == abort_at);
      if (done_cnt > 0 && rel >= done_cyc + 2) fin = 1;
      if (abort_at > 0 && rel >= abort_at + 3) fin = 1;
    end
    start = 1'b0; abort = 1'b0; src_on = 1'b0; u.s_valid = 1'b0;
    step();
    tests++;
    if (!fin) begin fails++; $display("FAIL frame_timeout: finished %0d required 1", fin); end
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL sb_leftover: got %0d entries required 0", sb.size()); end
  endtask

  task automatic test_reset();
    logic [W+7:0] o;
    u.s_data = '0; u.s_valid = 1'b0;
    sys_rst_n = 1'b0;
    step(); step();
    o = {u.s_ready, u.new_frame, u.data_in, u.data_vld, busy, done, cfg_err, underflow};
    tests++;
    if (o !== '0) begin fails++; $display("FAIL reset_outputs: got %h required 0", o); end
    sys_rst_n = 1'b1;
    step(); step();
    o = {u.s_ready, u.new_frame, u.data_in, u.data_vld, busy, done, cfg_err, underflow};
    tests++;
    if (o !== '0) begin fails++; $display("FAIL post_reset_idle: got %h required 0", o); end
  endtask

  task automatic test_nominal();
    int exp_v[4] = '{8, 9, 11, 12};
    logic [W-1:0] fd;
    run_frame(2, 16, -1, -1, 0, 0);
    tests++; if (nf_cyc != 1)    begin fails++; $display("FAIL nf_cycle: got %0d required 1", nf_cyc); end
    tests++; if (nf_cnt != 1)    begin fails++; $display("FAIL nf_count: got %0d required 1", nf_cnt); end
    tests++; if (busy_at1 != 1)  begin fails++; $display("FAIL busy_c1: got %0d required 1", busy_at1); end
    tests++; if (rdy_first != 7) begin fails++; $display("FAIL ready_first: got %0d required 7", rdy_first); end
    tests++; if (vld_q.size() != 4) begin fails++; $display("FAIL beat_count: got %0d required 4", vld_q.size()); end
    for (int i = 0; i < 4 && i < vld_q.size(); i++) begin
      tests++;
      if (vld_q[i] != exp_v[i]) begin fails++; $display("FAIL vld_cycle%0d: got %0d required %0d", i, vld_q[i], exp_v[i]); end
    end
    tests++; if (done_cyc != 12) begin fails++; $display("FAIL done_cycle: got %0d required 12", done_cyc); end
    tests++; if (done_cnt != 1)  begin fails++; $display("FAIL done_count: got %0d required 1", done_cnt); end
    tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL busy_after: got %b required 0", busy); end
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL nom_underflow: got %b required 0", underflow); end
    fd = first_data;
    tests++; if (fd[W-1 -: DW] !== 10'h001) begin fails++; $display("FAIL lane_msb: got %h required 001", fd[W-1 -: DW]); end
    tests++; if (fd[DW-1:0] !== 10'h008) begin fails++; $display("FAIL lane_lsb: got %h required 008", fd[DW-1:0]); end
  endtask

  task automatic test_bubble();
    run_frame(2, 16, -1, -1, 1, 3);
    tests++; if (vld_q.size() != 4) begin fails++; $display("FAIL bub_beats: got %0d required 4", vld_q.size()); end
    if (vld_q.size() >= 2) begin
      tests++;
      if (vld_q[1] - vld_q[0] != 4) begin fails++; $display("FAIL bub_gap: got %0d required 4", vld_q[1] - vld_q[0]); end
    end
    tests++; if (done_cyc != 15) begin fails++; $display("FAIL bub_done: got %0d required 15", done_cyc); end
    tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL bub_underflow: got %b required 1", underflow); end
  endtask

  task automatic test_cfg_err();
    int rs[3] = '{2, 0, 2};
    int cs[3] = '{12, 16, 0};
    for (int i = 0; i < 3; i++) begin
      rowSize = rs[i]; colSize = cs[i]; start = 1'b1;
      step();
      start = 1'b0;
      tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL cfgerr_pulse%0d: got %b required 1", i, cfg_err); end
      tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL cfgerr_busy%0d: got %b required 0", i, busy); end
      step();
      tests++; if (cfg_err !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL cfgerr_after%0d: got %b%b required 00", i, cfg_err, busy);
      end
    end
  endtask

  task automatic test_start_while_busy();
    run_frame(2, 16, -1, 5, 0, 0);
    tests++; if (cfgerr_cnt != 0)   begin fails++; $display("FAIL busy_start_cfgerr: got %0d required 0", cfgerr_cnt); end
    tests++; if (vld_q.size() != 4) begin fails++; $display("FAIL busy_start_beats: got %0d required 4", vld_q.size()); end
    tests++; if (done_cyc != 12)    begin fails++; $display("FAIL busy_start_done: got %0d required 12", done_cyc); end
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL underflow_clear: got %b required 0", underflow); end
  endtask

  task automatic test_abort();
    run_frame(2, 16, 11, -1, 0, 0);
    tests++; if (done_cnt != 0)     begin fails++; $display("FAIL abort_done: got %0d required 0", done_cnt); end
    tests++; if (busy_abort != 0)   begin fails++; $display("FAIL abort_busy: got %0d required 0", busy_abort); end
    tests++; if (vld_q.size() != 4) begin fails++; $display("FAIL abort_beats: got %0d required 4", vld_q.size()); end
    run_frame(2, 16, -1, -1, 0, 0);
    tests++; if (done_cnt != 1 || done_cyc != 12) begin
      fails++; $display("FAIL abort_rerun_done: got %0d@%0d required 1@12", done_cnt, done_cyc);
    end
    tests++; if (vld_q.size() != 4) begin fails++; $display("FAIL abort_rerun_beats: got %0d required 4", vld_q.size()); end
  endtask

  task automatic test_reset_mid_row();
    logic [W+7:0] o;
    hs_base = hs_total; last_b = 0; bubble_after = 0; bubble_rem = 0;
    u.s_data = pattern(0); src_on = 1'b1; u.s_valid = 1'b1;
    rowSize = 2; colSize = 16; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      start = 1'b0;
    end
    tests++; if (u.data_vld !== 1'b1) begin fails++; $display("FAIL midrow_active: got %b required 1", u.data_vld); end
    sys_rst_n = 1'b0;
    #1;
    o = {u.s_ready, u.new_frame, u.data_in, u.data_vld, busy, done, cfg_err, underflow};
    tests++; if (o !== '0) begin fails++; $display("FAIL midrow_reset: got %h required 0", o); end
    src_on = 1'b0;
    step(); step();
    sys_rst_n = 1'b1;
    sb.delete();
    step();
    run_frame(1, 8, -1, -1, 0, 0);
    tests++; if (vld_q.size() != 1) begin fails++; $display("FAIL rst_rerun_beats: got %0d required 1", vld_q.size()); end
    tests++; if (done_cnt != 1 || done_cyc != 8) begin
      fails++; $display("FAIL rst_rerun_done: got %0d@%0d required 1@8", done_cnt, done_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bubble();
    test_cfg_err();
    test_start_while_busy();
    test_abort();
    test_reset_mid_row();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_frame_pixel_tx
`default_nettype wire

// File: doc/frame_pixel_tx.md
# frame_pixel_tx

Frame transmitter that drives the BlurFilter pixel-input protocol (`new_frame`, `data_in`, `data_vld`) from an upstream ready/valid pixel stream. On a start request it issues the frame pulse, enforces lead-in and inter-row idle gaps, and meters exactly `rowSize` rows of `colSize/LANES` beats. It also reverses lane order so the first pixel lands in the MSB lane. It sits between the frame-buffer readout and the filter, replacing bench-driven stimulus in the integrated design.

## Interface
- `DWIDTH`, 10, bits per pixel
- `LANES`, 8, pixels per beat; power of two
- `LEAD`, 4, idle cycles between the `new_frame` cycle and the first row gap
- `ROW_GAP`, 1, idle cycles before every row (≥1)
- `sys_clk`  in  1  sole clock; everything is on the rising edge
- `sys_rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle frame request
- `abort`  in  1  synchronous frame cancel
- `rowSize`  in  32  rows per frame; latched at accepted start
- `colSize`  in  32  pixels per row; latched at accepted start
- `s_data`  in  LANES*DWIDTH  upstream pixels; lane 0 (bits [DWIDTH-1:0]) is the earliest pixel
- `s_valid`  in  1  upstream beat valid
- `s_ready`  out  1  beat accepted when `s_valid & s_ready`
- `new_frame`  out  1  one-cycle frame pulse to the filter
- `data_in`  out  LANES*DWIDTH  pixels; earliest pixel in the MSB lane
- `data_vld`  out  1  `data_in` valid
- `busy`  out  1  high from accepted start until done/abort
- `done`  out  1  one-cycle pulse after the last beat
- `cfg_err`  out  1  one-cycle pulse when a start is rejected
- `underflow`  out  1  sticky: a mid-row bubble occurred; cleared by an accepted start

## Operation
- States: IDLE, NEWF, LEAD, GAP, ROW, DONE.
- IDLE: `start` with `rowSize!=0`, `colSize!=0` and `colSize%LANES==0` latches config, clears `underflow` and goes to NEWF. A start that fails these checks pulses `cfg_err` and stays in IDLE.
- NEWF: `new_frame`=1 for exactly this cycle, then LEAD.
- LEAD: `LEAD` cycles, then GAP. If `LEAD`=0, go directly to GAP.
- GAP: `ROW_GAP` cycles with `s_ready`=0, then ROW with the beat counter cleared.
- ROW: `s_ready`=1. Each handshake increments the beat counter.
  - On beat `colSize/LANES-1` of a non-final row: go to GAP and increment the row counter.
  - On the final beat of the final row: go to DONE.
- ROW, `s_valid`=0 after the row's first beat: a bubble appears on `data_vld` and `underflow` is set. Waiting for the first beat is not an underflow.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` while `busy` is ignored. It does not pulse `cfg_err`.
- `abort` in any non-IDLE state forces IDLE next cycle. No `done` pulse. Any beat accepted in that cycle is still emitted.
- Lane swap: `data_in[(LANES-1-k)*DWIDTH +: DWIDTH] = s_data[k*DWIDTH +: DWIDTH]`.
- Beats per row = `colSize >> log2(LANES)`, held in a 32-bit counter. The row counter is also 32 bits. No wrap is possible within legal configs.

## Timing
- Reset (async assert, sync release) sets every output and state to 0/IDLE, including `underflow` and the counters.
- `start` sampled at cycle 0 → `new_frame` at cycle 1 → first `s_ready` at cycle 2+LEAD+ROW_GAP.
- `s_ready` is decoded from the registered state only, with no combinational path from `s_valid`.
- `data_in`/`data_vld` are registered: a handshake at cycle t gives `data_vld`=1 at t+1. `data_in` holds its last value when `data_vld`=0.
- `done` is asserted the cycle after the final handshake, coincident with the final `data_vld`.
- `start` and `abort` in the same IDLE cycle: start wins. Outside IDLE, abort wins.
- Reset mid-row: outputs drop immediately; no partial `done`.

## Structure
- Package `frame_tx_pkg`: state enum `tx_state_t`, default `DWIDTH`/`LANES` constants, and the `cfg_ok` check function.
- Sub-module `pixel_lane_swap` (parameterised combinational reverse), reused by the capture path.
- Top: FSM, beat counter, row counter, LEAD/GAP counter, output registers.

## Test plan
- Nominal frame, `rowSize`=2, `colSize`=16, upstream always valid:
  - `new_frame` at cycle 1.
  - Row 0 `data_vld` at cycles 8–9 and row 1 at cycles 11–12, so exactly 4 beats.
  - `done` at cycle 12.
- Lane order, `s_data` = lanes 0..7 holding 0x001..0x008 → `data_in` MSB lane = 0x001 and LSB lane = 0x008.
- Upstream bubble: `s_valid` low for 3 cycles after the first beat of row 0 → 3-cycle `data_vld` gap, `underflow`=1. Total beat count is still 4.
- Config errors:
  - `colSize`=12 → `cfg_err` pulse, `busy` stays 0.
  - `rowSize`=0 → same response.
  - `start` while busy → ignored, frame completes normally.
- Abort at the 2nd beat of row 1 → IDLE next cycle, no `done`, `busy`=0. A following start runs a full frame.
- Async reset asserted mid-row:
  - All outputs 0 in the same cycle.
  - After release, a start with `rowSize`=1, `colSize`=8 yields 1 beat and `done`.
